css_mcu0_el2_ifu_iccm_dma_arb: RTL and testbench

This block is the ICCM access scheduler between instruction fetch and DMA. It grants DMA beats when the fetch pipe reports the ICCM free, and tracks outstanding DMA reads. When a DMA request starves, it forces a fetch stall through `dma_iccm_stall_any`, grants a bounded burst, then enforces a fetch holdoff. It sits beside the IFU fetch control, consumes its `ifc_dma_access_ok`, and drives its `dma_iccm_stall_any` input.

---
 rtl/css_mcu0_el2_pkg.sv | 11 +
 rtl/css_mcu0_el2_ifu_iccm_dma_arb.sv | 116 +++++++++++
 tb/tb_css_mcu0_el2_ifu_iccm_dma_arb.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/css_mcu0_el2_pkg.sv
// Shared types for the css_mcu0 EL2 fetch/DMA slice.
package css_mcu0_el2_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    FORCE   = 2'd2,
    HOLDOFF = 2'd3
  } el2_iccm_arb_state_t;

endpackage

// File: rtl/css_mcu0_el2_ifu_iccm_dma_arb.sv
// ICCM access scheduler between fetch and DMA: natural grants, starvation-forced
// fetch stalls with a bounded burst and holdoff, and DMA read-return tracking.
module css_mcu0_el2_ifu_iccm_dma_arb
  import css_mcu0_el2_pkg::*;
#(
  parameter int DMA_MAX_WAIT  = 8,
  parameter int DMA_BURST_MAX = 4,
  parameter int FETCH_HOLDOFF = 2,
  parameter int ICCM_RD_LAT   = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic ifc_dma_access_ok,
  input  logic dma_iccm_req,
  input  logic dma_mem_write,
  output logic dma_iccm_grant,
  output logic dma_iccm_stall_any,
  output logic iccm_dma_rvalid,
  output logic iccm_dma_busy
);

  localparam int WCNT_W = $clog2(DMA_MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(DMA_MAX_WAIT - 1);
  localparam logic [3:0] BCNT_LAST = 4'(DMA_BURST_MAX - 1);
  localparam logic [3:0] HCNT_LAST = 4'(FETCH_HOLDOFF - 1);

  el2_iccm_arb_state_t state_r, state_nxt_s;
  logic [WCNT_W-1:0] wcnt_r, wcnt_nxt_s;
  logic [3:0] bcnt_r, bcnt_nxt_s;
  logic [3:0] hcnt_r, hcnt_nxt_s;
  logic [ICCM_RD_LAT-1:0] rd_pipe_r;
  logic [ICCM_RD_LAT:0] rd_ext_s;
  logic grant_s, rd_s;

  assign grant_s = ~rst & dma_iccm_req & ifc_dma_access_ok;
  assign rd_s    = grant_s & ~dma_mem_write;
  // Stage 0 of the extended vector is this cycle's read grant, so busy covers the grant cycle.
  assign rd_ext_s = {rd_pipe_r, rd_s};

  assign dma_iccm_grant     = grant_s;
  assign dma_iccm_stall_any = (state_r == FORCE);
  assign iccm_dma_rvalid    = ~rst & rd_pipe_r[ICCM_RD_LAT-1];
  assign iccm_dma_busy      = ~rst & (|rd_ext_s[ICCM_RD_LAT-1:0]);

  // Next-state and counter updates for the starvation scheduler.
  always_comb begin
    state_nxt_s = state_r;
    wcnt_nxt_s  = '0;
    bcnt_nxt_s  = bcnt_r;
    hcnt_nxt_s  = hcnt_r;
    case (state_r)
      IDLE: begin
        if (dma_iccm_req && !grant_s) begin
          state_nxt_s = WAIT;
          wcnt_nxt_s  = WCNT_W'(1);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (!dma_iccm_req) begin
          state_nxt_s = IDLE;
        end else if (grant_s) begin
          state_nxt_s = WAIT;
        end else if (wcnt_r == WCNT_LAST) begin
          state_nxt_s = FORCE;
          bcnt_nxt_s  = 4'd0;
        end else begin
          wcnt_nxt_s = wcnt_r + WCNT_W'(1);
        end
      end
      FORCE: begin
        if (!dma_iccm_req || (grant_s && (bcnt_r == BCNT_LAST))) begin
          state_nxt_s = HOLDOFF;
          bcnt_nxt_s  = 4'd0;
          hcnt_nxt_s  = 4'd0;
        end else if (grant_s) begin
          bcnt_nxt_s = bcnt_r + 4'd1;
        end else begin
          bcnt_nxt_s = bcnt_r;
        end
      end
      HOLDOFF: begin
        if (hcnt_r == HCNT_LAST) begin
          hcnt_nxt_s  = 4'd0;
          state_nxt_s = dma_iccm_req ? WAIT : IDLE;
        end else begin
          hcnt_nxt_s = hcnt_r + 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        bcnt_nxt_s  = 4'd0;
        hcnt_nxt_s  = 4'd0;
      end
    endcase
  end

  // State, counters and read-return pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      wcnt_r    <= '0;
      bcnt_r    <= 4'd0;
      hcnt_r    <= 4'd0;
      rd_pipe_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      wcnt_r    <= wcnt_nxt_s;
      bcnt_r    <= bcnt_nxt_s;
      hcnt_r    <= hcnt_nxt_s;
      rd_pipe_r <= rd_ext_s[ICCM_RD_LAT-1:0];
    end
  end

endmodule

// File: tb/tb_css_mcu0_el2_ifu_iccm_dma_arb.sv
// Directed bench for the ICCM DMA arbiter with a starvation-count reference model.
module tb_css_mcu0_el2_ifu_iccm_dma_arb;

  localparam int MAXW  = 8;
  localparam int BURST = 4;
  localparam int HOLD  = 2;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic rst, req, wr, follow, ok_val, prev_stall;
  logic ok;
  logic grant, stall, rvalid, busy;

  int total = 0;
  int passed = 0;

  // Reference model state: starved-cycle run, burst grants, holdoff cycles left.
  bit m_stall;
  int m_run, m_burst, m_hold;
  logic [7:0] hist;
  bit started = 1'b0;
  logic e_grant, rd_now, e_busy, e_rvalid;

  // Scenario logs.
  int tcyc, first_grant, first_stall, grants_in_stall, burst1, grant_cnt;
  int stall_cnt, rvalid_cnt, rvalid_cyc, stall_rises, rise2;
  logic [15:0] busy_mask;
  logic [3:0] outs_at2;
  bit stall_d;

  css_mcu0_el2_ifu_iccm_dma_arb #(
    .DMA_MAX_WAIT(MAXW), .DMA_BURST_MAX(BURST),
    .FETCH_HOLDOFF(HOLD), .ICCM_RD_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .ifc_dma_access_ok(ok), .dma_iccm_req(req), .dma_mem_write(wr),
    .dma_iccm_grant(grant), .dma_iccm_stall_any(stall),
    .iccm_dma_rvalid(rvalid), .iccm_dma_busy(busy)
  );

  always #5 clk = ~clk;

  // Fetch control flops the stall and offers the ICCM while the flopped copy is high.
  always @(posedge clk) prev_stall <= rst ? 1'b0 : stall;
  assign ok = follow ? prev_stall : ok_val;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, tcyc);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    if (started) begin
      e_grant = !rst && req && ok;
      check("grant", grant, e_grant);
      if (rst) begin
        check("rvalid_in_rst", rvalid, 1'b0);
        check("busy_in_rst", busy, 1'b0);
        m_stall = 1'b0; m_run = 0; m_burst = 0; m_hold = 0;
        hist = '0; stall_d = 1'b0;
      end else begin
        rd_now   = e_grant && !wr;
        e_rvalid = hist[LAT-1];
        e_busy   = rd_now;
        for (int d = 0; d < LAT - 1; d++) e_busy = e_busy | hist[d];
        check("stall", stall, m_stall);
        check("rvalid", rvalid, e_rvalid);
        check("busy", busy, e_busy);

        if (grant) begin
          grant_cnt++;
          if (first_grant < 0) first_grant = tcyc;
          if (stall) grants_in_stall++;
          if (stall && tcyc < 20) burst1++;
        end
        if (stall) begin
          stall_cnt++;
          if (first_stall < 0) first_stall = tcyc;
          if (!stall_d) begin
            stall_rises++;
            if (stall_rises == 2) rise2 = tcyc;
          end
        end
        stall_d = stall;
        if (rvalid) begin rvalid_cnt++; rvalid_cyc = tcyc; end
        if (busy && tcyc < 16) busy_mask[tcyc] = 1'b1;
        if (tcyc == 2) outs_at2 = {grant, stall, rvalid, busy};

        if (m_stall) begin
          if (!req || (e_grant && (m_burst + 1 == BURST))) begin
            m_stall = 1'b0; m_burst = 0; m_hold = HOLD;
          end else if (e_grant) m_burst++;
        end else if (m_hold > 0) begin
          m_hold--; m_run = 0;
        end else if (req && !e_grant) begin
          m_run++;
          if (m_run == MAXW) begin m_stall = 1'b1; m_run = 0; end
        end else m_run = 0;
        hist = {hist[6:0], rd_now};
      end
      tcyc++;
    end
  end

  task automatic cyc(input logic r, input logic q, input logic w, input logic f, input logic o);
    rst = r; req = q; wr = w; follow = f; ok_val = o;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tcyc = 0; first_grant = -1; first_stall = -1; grants_in_stall = 0; burst1 = 0;
    grant_cnt = 0; stall_cnt = 0; rvalid_cnt = 0; rvalid_cyc = -1;
    stall_rises = 0; rise2 = -1; busy_mask = '0; outs_at2 = 4'hf;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; follow = 1'b0; ok_val = 1'b0;
    hist = '0;
    @(posedge clk); #1;
    started = 1'b1;

    // Free ICCM read.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_int("free_first_grant", first_grant, 0);
    check_int("free_rvalid_cnt", rvalid_cnt, 1);
    check_int("free_rvalid_cyc", rvalid_cyc, 2);
    check_int("free_busy_mask", int'(busy_mask), 3);
    check_int("free_stall_cnt", stall_cnt, 0);

    // Starvation with fetch-control feedback, two forced episodes.
    do_reset();
    repeat (26) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_int("starve_first_stall", first_stall, 8);
    check_int("starve_first_grant", first_grant, 9);
    check_int("starve_burst1", burst1, 4);
    check_int("starve_second_force", rise2, 23);
    check_int("starve_stall_cycles", stall_cnt, 9);
    check_int("starve_grants", grant_cnt, 7);
    check_int("starve_grants_in_stall", grants_in_stall, 6);

    // Abandoned wait at wcnt=5, then a fresh 8-cycle wait that must not force yet.
    do_reset();
    repeat (5) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_int("abandon_stall_cnt", stall_cnt, 0);
    check_int("abandon_grants", grant_cnt, 0);

    // Reset in the cycle after a read grant.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_int("rstmid_first_grant", first_grant, 0);
    check_int("rstmid_rvalid_cnt", rvalid_cnt, 0);
    check_int("rstmid_outs_at2", int'(outs_at2), 0);

    // Write then read back to back.
    do_reset();
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_int("mixed_grants", grant_cnt, 2);
    check_int("mixed_rvalid_cnt", rvalid_cnt, 1);
    check_int("mixed_rvalid_cyc", rvalid_cyc, 3);

    // Grant on the cycle the wait limit would be hit.
    do_reset();
    repeat (7) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (7) cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_int("limit_stall_cnt", stall_cnt, 0);
    check_int("limit_first_grant", first_grant, 7);
    check_int("limit_grants", grant_cnt, 1);

    started = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
